// File: rtl/alu_issue_arbiter.sv
// Two-requester arbiter sharing one 32-bit ALU with a one-entry registered output stage.
// Define ALU_ISSUE_ARBITER_STATS_EN to add saturating grant/conflict counters.
module alu_issue_arbiter #(
   parameter int unsigned ARB_MODE = 1,
   parameter int unsigned OP_W     = 12
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [OP_W-1:0] req0_op,
   input  logic [31:0]     req0_src1,
   input  logic [31:0]     req0_src2,
   input  logic            req0_ov_en,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [OP_W-1:0] req1_op,
   input  logic [31:0]     req1_src1,
   input  logic [31:0]     req1_src2,
   input  logic            req1_ov_en,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_id,
   output logic [31:0]     out_result,
   output logic            out_ov,
   output logic            out_illegal
`ifdef ALU_ISSUE_ARBITER_STATS_EN
   ,
   output logic [31:0]     grant_cnt0,
   output logic [31:0]     grant_cnt1,
   output logic [31:0]     conflict_cnt
`endif
);

   localparam logic [OP_W-1:0] OP_ADD  = 12'h001;
   localparam logic [OP_W-1:0] OP_SUB  = 12'h002;
   localparam logic [OP_W-1:0] OP_SLT  = 12'h004;
   localparam logic [OP_W-1:0] OP_SLTU = 12'h008;
   localparam logic [OP_W-1:0] OP_AND  = 12'h010;
   localparam logic [OP_W-1:0] OP_NOR  = 12'h020;
   localparam logic [OP_W-1:0] OP_OR   = 12'h040;
   localparam logic [OP_W-1:0] OP_XOR  = 12'h080;
   localparam logic [OP_W-1:0] OP_SLL  = 12'h100;
   localparam logic [OP_W-1:0] OP_SRL  = 12'h200;
   localparam logic [OP_W-1:0] OP_SRA  = 12'h400;
   localparam logic [OP_W-1:0] OP_LUI  = 12'h800;

   logic            last_grant;
   logic            accept;
   logic            grant0;
   logic            grant1;
   logic            xfer;
   logic [OP_W-1:0] sel_op;
   logic [31:0]     sel_a;
   logic [31:0]     sel_b;
   logic            sel_ov_en;
   logic [31:0]     sum;
   logic [31:0]     diff;
   logic [4:0]      shamt;
   logic            illegal;
   logic [31:0]     alu_res;
   logic            alu_ov;

   assign accept = !out_valid | out_ready;

   always_comb begin
      grant1 = 1'b0;
      if (req0_valid && req1_valid) begin
         grant1 = (ARB_MODE != 0) ? (last_grant == 1'b0) : 1'b0;
      end else begin
         grant1 = req1_valid;
      end
   end

   assign grant0     = req0_valid & !grant1;
   assign req0_ready = grant0 & accept;
   assign req1_ready = grant1 & accept;
   assign xfer       = (req0_valid & req0_ready) | (req1_valid & req1_ready);

   assign sel_op    = grant1 ? req1_op    : req0_op;
   assign sel_a     = grant1 ? req1_src1  : req0_src1;
   assign sel_b     = grant1 ? req1_src2  : req0_src2;
   assign sel_ov_en = grant1 ? req1_ov_en : req0_ov_en;

   assign sum     = sel_a + sel_b;
   assign diff    = sel_a - sel_b;
   assign shamt   = sel_a[4:0];
   // Zero ops and multi-hot ops are both rejected.
   assign illegal = (sel_op == '0) || ((sel_op & (sel_op - 1'b1)) != '0);

   always_comb begin
      alu_res = '0;
      alu_ov  = 1'b0;
      case (sel_op)
         OP_ADD: begin
            alu_res = sum;
            alu_ov  = (sel_a[31] == sel_b[31]) && (sum[31] != sel_a[31]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ov  = (sel_a[31] != sel_b[31]) && (diff[31] != sel_a[31]);
         end
         OP_SLT:  alu_res = {31'b0, $signed(sel_a) < $signed(sel_b)};
         OP_SLTU: alu_res = {31'b0, sel_a < sel_b};
         OP_AND:  alu_res = sel_a & sel_b;
         OP_NOR:  alu_res = ~(sel_a | sel_b);
         OP_OR:   alu_res = sel_a | sel_b;
         OP_XOR:  alu_res = sel_a ^ sel_b;
         OP_SLL:  alu_res = sel_b << shamt;
         OP_SRL:  alu_res = sel_b >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(sel_b) >>> shamt);
         OP_LUI:  alu_res = {sel_b[15:0], 16'h0000};
         default: begin
            alu_res = '0;
            alu_ov  = 1'b0;
         end
      endcase
      if (illegal) begin
         alu_res = '0;
         alu_ov  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid   <= 1'b0;
         out_id      <= 1'b0;
         out_result  <= '0;
         out_ov      <= 1'b0;
         out_illegal <= 1'b0;
         last_grant  <= 1'b1;
      end else if (xfer) begin
         out_valid   <= 1'b1;
         out_id      <= grant1;
         out_result  <= alu_res;
         out_ov      <= alu_ov & sel_ov_en;
         out_illegal <= illegal;
         last_grant  <= grant1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef ALU_ISSUE_ARBITER_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt0   <= '0;
         grant_cnt1   <= '0;
         conflict_cnt <= '0;
      end else begin
         if (xfer && !grant1 && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 1'b1;
         if (xfer && grant1 && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + 1'b1;
         if (req0_valid && req1_valid && accept && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
         end
      end
   end
`endif

endmodule
